// File: rtl/fir_product_gen_if.sv
// rtl/fir_product_gen_if.sv - sample, coefficient and product-array signals of the FIR front end
interface fir_product_gen_if #(
    parameter int NUM_TAPS = 101,
    parameter int DATA_W   = 24,
    parameter int COEF_W   = 17,
    parameter int PROD_W   = 42
);
    localparam int NUM_PROD = (NUM_TAPS + 1) / 2;

    logic                     sample_valid;
    logic signed [DATA_W-1:0] sample_in;
    logic                     flush;
    logic                     coef_we;
    logic [5:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic signed [PROD_W-1:0] product [NUM_PROD];
    logic                     product_valid;
    logic                     primed;

    modport master (
        output sample_valid, sample_in, flush, coef_we, coef_addr, coef_data,
        input  product, product_valid, primed
    );

    modport slave (
        input  sample_valid, sample_in, flush, coef_we, coef_addr, coef_data,
        output product, product_valid, primed
    );
endinterface

// File: rtl/fir_product_gen.sv
// rtl/fir_product_gen.sv - symmetric FIR front end: delay line, pre-adders, coefficient multiplies
module fir_product_gen #(
    parameter int NUM_TAPS = 101,
    parameter int DATA_W   = 24,
    parameter int COEF_W   = 17,
    parameter int PROD_W   = 42
) (
    input  logic            clk,
    input  logic            rst,
    fir_product_gen_if.slave bus
);
    localparam int NUM_PROD = (NUM_TAPS + 1) / 2;
    localparam int CNT_W    = $clog2(NUM_TAPS + 1);
    localparam int EXT_P    = PROD_W - DATA_W - 1;
    localparam int EXT_C    = PROD_W - COEF_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_TAPS);
    localparam logic [5:0]       ADDR_LIM = 6'(NUM_PROD);

    logic signed [DATA_W-1:0] x_q    [NUM_TAPS];
    logic signed [DATA_W-1:0] x_d    [NUM_TAPS];
    logic signed [COEF_W-1:0] c_q    [NUM_PROD];
    logic signed [COEF_W-1:0] c_d    [NUM_PROD];
    logic signed [DATA_W:0]   p_q    [NUM_PROD];
    logic signed [DATA_W:0]   p_d    [NUM_PROD];
    logic signed [COEF_W-1:0] cs_q   [NUM_PROD];
    logic signed [COEF_W-1:0] cs_d   [NUM_PROD];
    logic signed [PROD_W-1:0] prod_q [NUM_PROD];
    logic signed [PROD_W-1:0] prod_d [NUM_PROD];
    logic [2:0]               vld_q, vld_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     primed_q, primed_d;

    always_comb begin
        x_d = x_q;
        if (bus.flush) begin
            for (int k = 0; k < NUM_TAPS; k++) x_d[k] = '0;
        end else if (bus.sample_valid) begin
            x_d[0] = bus.sample_in;
            for (int k = 1; k < NUM_TAPS; k++) x_d[k] = x_q[k-1];
        end
    end

    // Coefficients survive flush; out-of-range addresses are dropped.
    always_comb begin
        c_d = c_q;
        if (bus.coef_we && (bus.coef_addr < ADDR_LIM)) c_d[bus.coef_addr] = bus.coef_data;
    end

    always_comb begin
        p_d  = p_q;
        cs_d = cs_q;
        if (bus.flush) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                p_d[i]  = '0;
                cs_d[i] = '0;
            end
        end else if (vld_q[0]) begin
            for (int i = 0; i < NUM_PROD - 1; i++) begin
                p_d[i] = $signed({x_q[i][DATA_W-1], x_q[i]})
                       + $signed({x_q[NUM_TAPS-1-i][DATA_W-1], x_q[NUM_TAPS-1-i]});
            end
            p_d[NUM_PROD-1] = $signed({x_q[NUM_PROD-1][DATA_W-1], x_q[NUM_PROD-1]});
            cs_d = c_q;
        end
    end

    // Operands widened to PROD_W so the signed product is exact.
    always_comb begin
        prod_d = prod_q;
        if (bus.flush) begin
            for (int i = 0; i < NUM_PROD; i++) prod_d[i] = '0;
        end else if (vld_q[1]) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                prod_d[i] = $signed({{EXT_P{p_q[i][DATA_W]}}, p_q[i]})
                          * $signed({{EXT_C{cs_q[i][COEF_W-1]}}, cs_q[i]});
            end
        end
    end

    always_comb begin
        vld_d    = bus.flush ? 3'b000 : {vld_q[1:0], bus.sample_valid};
        cnt_d    = cnt_q;
        if (bus.flush) begin
            cnt_d = '0;
        end else if (bus.sample_valid && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        primed_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) x_q[k] <= '0;
            for (int i = 0; i < NUM_PROD; i++) begin
                c_q[i]    <= '0;
                p_q[i]    <= '0;
                cs_q[i]   <= '0;
                prod_q[i] <= '0;
            end
            vld_q    <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            c_q      <= c_d;
            p_q      <= p_d;
            cs_q     <= cs_d;
            prod_q   <= prod_d;
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
        end
    end

    assign bus.product       = prod_q;
    assign bus.product_valid = vld_q[2];
    assign bus.primed        = primed_q;
endmodule
